// File: rtl/div_sequencer_pkg.sv
// Shared ALU package: divider sequencer state encoding and defaults.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } div_state_e;

    localparam int unsigned DIV_N_DEF       = 4;
    localparam int unsigned DIV_TIMEOUT_DEF = 2 * DIV_N_DEF + 4;

    // Quotient reported on divide-by-zero; sliced to the operand width.
    localparam logic [63:0] DIV_DBZ_Q = '1;

endpackage

// File: rtl/div_watchdog.sv
// Clearable saturating cycle counter guarding the divider wait.
module div_watchdog #(
    parameter int TIMEOUT = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != W'(TIMEOUT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/div_sequencer.sv
// Issue/response sequencer in front of the iterative divider; trivial
// cases are answered locally, the rest wait on the divider under a watchdog.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int N       = DIV_N_DEF,
    parameter int TIMEOUT = 2 * N + 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         div_start,
    output logic [N-1:0] div_a,
    output logic [N-1:0] div_b,
    input  logic         div_done,
    input  logic [N-1:0] div_q,
    input  logic [N-1:0] div_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_q,
    output logic [N-1:0] out_r,
    output logic         out_dbz,
    output logic         out_err
);

    div_state_e   state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] r_q, r_d;
    logic         dbz_q, dbz_d;
    logic         err_q, err_d;
    logic         wd_clr;
    logic         wd_en;
    logic         wd_expired;

    div_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            q_q   <= q_d;
            r_q   <= r_d;
            dbz_q <= dbz_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (in_b == '0) begin
                        state_d = S_RESP;
                        q_d     = DIV_DBZ_Q[N-1:0];
                        r_d     = in_a;
                        dbz_d   = 1'b1;
                    end else if (in_a < in_b) begin
                        state_d = S_RESP;
                        q_d     = '0;
                        r_d     = in_a;
                    end else if (in_b == N'(1)) begin
                        state_d = S_RESP;
                        q_d     = in_a;
                        r_d     = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done pulse on the final watchdog cycle still wins.
                if (div_done) begin
                    state_d = S_RESP;
                    q_d     = div_q;
                    r_d     = div_r;
                end else if (wd_expired) begin
                    state_d = S_RESP;
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        div_start = (state_q == S_ISSUE);
        out_valid = (state_q == S_RESP);
        wd_clr    = (state_q == S_ISSUE);
        wd_en     = (state_q == S_WAIT);
    end

    assign div_a   = a_q;
    assign div_b   = b_q;
    assign out_q   = q_q;
    assign out_r   = r_q;
    assign out_dbz = dbz_q;
    assign out_err = err_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer with a divider model.
module tb_div_sequencer;

    localparam int N       = 4;
    localparam int TIMEOUT = 2 * N + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         div_start;
    logic [N-1:0] div_a;
    logic [N-1:0] div_b;
    logic         div_done;
    logic [N-1:0] div_q;
    logic [N-1:0] div_r;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_q;
    logic [N-1:0] out_r;
    logic         out_dbz;
    logic         out_err;

    logic         model_done;
    logic         stray_done;
    int           model_k;
    bit           model_hang;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign div_done = model_done | stray_done;

    div_sequencer #(
        .N      (N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .div_start(div_start),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_done (div_done),
        .div_q    (div_q),
        .div_r    (div_r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q    (out_q),
        .out_r    (out_r),
        .out_dbz  (out_dbz),
        .out_err  (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Divider model: real division, done pulsed in the k-th wait cycle.
    initial begin
        logic [N-1:0] ka, kb;
        model_done = 1'b0;
        div_q      = '0;
        div_r      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (div_start && !model_hang) begin
                ka = div_a;
                kb = div_b;
                repeat (model_k + 1) @(posedge clk);
                #1;
                model_done = 1'b1;
                div_q      = ka / kb;
                div_r      = ka % kb;
                @(posedge clk);
                #1;
                model_done = 1'b0;
            end
        end
    end

    // Reference: what the consumer should see, and after how many clock
    // edges (counting the accepting edge) the result becomes valid.
    task automatic ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int k, input bit hang,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output bit dbz, output bit err,
                          output int starts, output int lat);
        dbz    = 0;
        err    = 0;
        starts = 0;
        lat    = 1;
        if (b == 0) begin
            q   = {N{1'b1}};
            r   = a;
            dbz = 1;
        end else if (a < b) begin
            q = 0;
            r = a;
        end else if (b == 1) begin
            q = a;
            r = 0;
        end else begin
            starts = 1;
            if (hang || k >= TIMEOUT) begin
                q   = 0;
                r   = 0;
                err = 1;
                lat = TIMEOUT + 2;
            end else begin
                q   = a / b;
                r   = a % b;
                lat = k + 3;
            end
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int k, input bit hang, input int gap,
                          input int idle_gap);
        logic [N-1:0] eq, er;
        bit edbz, eerr;
        int estarts, elat, lat, starts;
        ref_op(a, b, k, hang, eq, er, edbz, eerr, estarts, elat);
        in_valid = 1'b0;
        repeat (idle_gap) tick();
        chk("in_ready_idle", in_ready, 1);
        model_k    = k;
        model_hang = hang;
        in_a       = a;
        in_b       = b;
        in_valid   = 1'b1;
        tick();
        lat      = 1;
        starts   = 0;
        in_valid = 1'b0;
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        while (!out_valid && lat < 200) begin
            chk("in_ready_busy", in_ready, 0);
            if (div_start) begin
                starts++;
                chk("div_a", div_a, a);
                chk("div_b", div_b, b);
            end
            tick();
            lat++;
        end
        chk("resp_seen", out_valid, 1);
        chk("latency", lat, elat);
        chk("start_cnt", starts, estarts);
        for (int i = 0; i <= gap; i++) begin
            chk("out_q", out_q, eq);
            chk("out_r", out_r, er);
            chk("out_dbz", out_dbz, edbz);
            chk("out_err", out_err, eerr);
            chk("in_ready_resp", in_ready, 0);
            if (i < gap) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
        chk("dbz_clr", out_dbz, 0);
        chk("err_clr", out_err, 0);
        chk("q_retain", out_q, eq);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        stray_done = 1'b0;
        model_k    = 0;
        model_hang = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_dbz", out_dbz, 0);
        chk("rst_err", out_err, 0);
        chk("rst_q", out_q, 0);
        chk("rst_r", out_r, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);

        run_op(4'd9, 4'd0, 0, 0, 0, 0);
        run_op(4'd3, 4'd7, 0, 0, 1, 0);
        run_op(4'd11, 4'd1, 0, 0, 0, 1);
        run_op(4'd13, 4'd4, 2, 0, 4, 0);
        run_op(4'd14, 4'd3, 0, 1, 2, 0);
        run_op(4'd14, 4'd3, TIMEOUT - 1, 0, 0, 0);
        run_op(4'd14, 4'd3, TIMEOUT, 0, 0, 1);
        run_op(4'd15, 4'd15, 0, 0, 0, 0);

        // Reset while waiting on a hung divider, then a stray done.
        model_hang = 1'b1;
        in_a       = 4'd14;
        in_b       = 4'd3;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_div_start", div_start, 0);
        chk("mid_rst_err", out_err, 0);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_out_valid", out_valid, 0);
        chk("stray_in_ready", in_ready, 1);
        tick();
        chk("stray_out_valid2", out_valid, 0);

        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom_range(0, 15));
            rb = N'($urandom_range(0, 15));
            run_op(ra, rb, $urandom_range(0, TIMEOUT),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
